// File: rtl/fir_controller.sv
// Sequencing controller for a 4-tap FIR datapath: coefficient loads, sample store,
// delay-line shift and alternating-sign multiply-accumulate, with error reporting.
module fir_controller #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_ready,
  input  logic              load_coeff,
  input  logic [1:0]        coefficient_num,
  input  logic              overflow,
  output logic              modwait,
  output logic [OP_W-1:0]   op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              cnt_up,
  output logic              clear,
  output logic              err
);

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_COPY = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LOAD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(6);

  typedef enum logic [4:0] {
    IDLE   = 5'd0,  EIDLE  = 5'd1,  LOADC  = 5'd2,  STORE  = 5'd3,
    ZERO   = 5'd4,  SHIFT3 = 5'd5,  SHIFT2 = 5'd6,  SHIFT1 = 5'd7,
    SHIFT0 = 5'd8,  MUL0   = 5'd9,  ADD0   = 5'd10, MUL1   = 5'd11,
    SUB1   = 5'd12, MUL2   = 5'd13, ADD2   = 5'd14, MUL3   = 5'd15,
    SUB3   = 5'd16
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; overflow only matters on the accumulate steps.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, EIDLE: begin
        if (data_ready)      state_d = STORE;
        else if (load_coeff) state_d = LOADC;
        else                 state_d = state_q;
      end
      LOADC:  state_d = IDLE;
      STORE:  state_d = data_ready ? ZERO : EIDLE;
      ZERO:   state_d = SHIFT3;
      SHIFT3: state_d = SHIFT2;
      SHIFT2: state_d = SHIFT1;
      SHIFT1: state_d = SHIFT0;
      SHIFT0: state_d = MUL0;
      MUL0:   state_d = ADD0;
      ADD0:   state_d = overflow ? EIDLE : MUL1;
      MUL1:   state_d = SUB1;
      SUB1:   state_d = overflow ? EIDLE : MUL2;
      MUL2:   state_d = ADD2;
      ADD2:   state_d = overflow ? EIDLE : MUL3;
      MUL3:   state_d = SUB3;
      SUB3:   state_d = overflow ? EIDLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register map: R0 acc, R1..R4 taps, R5..R8 coefficients, R9 staging, R10 product.
  always_comb begin
    op      = OP_NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    err     = 1'b0;
    modwait = 1'b1;
    case (state_q)
      IDLE:  modwait = 1'b0;
      EIDLE: begin modwait = 1'b0; err = 1'b1; end
      LOADC: begin
        op    = OP_LOAD;
        dest  = ADDR_W'(5) + ADDR_W'(coefficient_num);
        clear = (coefficient_num == 2'd0);
      end
      STORE:  begin op = OP_LOAD; dest = ADDR_W'(9); cnt_up = 1'b1; end
      ZERO:   begin op = OP_SUB; src1 = ADDR_W'(0); src2 = ADDR_W'(0); dest = ADDR_W'(0); end
      SHIFT3: begin op = OP_COPY; src1 = ADDR_W'(3); dest = ADDR_W'(4); end
      SHIFT2: begin op = OP_COPY; src1 = ADDR_W'(2); dest = ADDR_W'(3); end
      SHIFT1: begin op = OP_COPY; src1 = ADDR_W'(1); dest = ADDR_W'(2); end
      SHIFT0: begin op = OP_COPY; src1 = ADDR_W'(9); dest = ADDR_W'(1); end
      MUL0:   begin op = OP_MUL; src1 = ADDR_W'(1); src2 = ADDR_W'(5); dest = ADDR_W'(10); end
      ADD0:   begin op = OP_ADD; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      MUL1:   begin op = OP_MUL; src1 = ADDR_W'(2); src2 = ADDR_W'(6); dest = ADDR_W'(10); end
      SUB1:   begin op = OP_SUB; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      MUL2:   begin op = OP_MUL; src1 = ADDR_W'(3); src2 = ADDR_W'(7); dest = ADDR_W'(10); end
      ADD2:   begin op = OP_ADD; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      MUL3:   begin op = OP_MUL; src1 = ADDR_W'(4); src2 = ADDR_W'(8); dest = ADDR_W'(10); end
      SUB3:   begin op = OP_SUB; src1 = ADDR_W'(0); src2 = ADDR_W'(10); dest = ADDR_W'(0); end
      default: modwait = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fir_controller.sv
// Directed-vector bench for fir_controller: each record drives one clock of inputs and
// gives the hand-derived Moore outputs expected right after that edge.
module tb_fir_controller;

  logic       clk = 1'b0;
  logic       reset, data_ready, load_coeff, overflow;
  logic [1:0] coefficient_num;
  logic       modwait, cnt_up, clear, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  fir_controller #(.ADDR_W(4), .OP_W(3)) dut (
    .clk(clk), .reset(reset), .data_ready(data_ready), .load_coeff(load_coeff),
    .coefficient_num(coefficient_num), .overflow(overflow), .modwait(modwait),
    .op(op), .src1(src1), .src2(src2), .dest(dest), .cnt_up(cnt_up),
    .clear(clear), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, dr, lc;
    logic [1:0] cn;
    logic       ov;
    logic [2:0] op;
    logic [3:0] s1, s2, d;
    logic       mw, cu, cl, er;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic v(input logic rst, dr, lc, input logic [1:0] cn, input logic ov,
                   input logic [2:0] op_e, input logic [3:0] s1, s2, d,
                   input logic mw, cu, cl, er);
    vec_t t;
    t.rst = rst; t.dr = dr; t.lc = lc; t.cn = cn; t.ov = ov;
    t.op = op_e; t.s1 = s1; t.s2 = s2; t.d = d;
    t.mw = mw; t.cu = cu; t.cl = cl; t.er = er;
    vecs.push_back(t);
  endtask

  // Expected-output shorthand for the fixed 12-step datapath body after ZERO.
  task automatic body_from_shift3(input int stop_after);
    // stop_after counts states emitted starting at SHIFT3 (max 12)
    logic [2:0] o[12]  = '{1, 1, 1, 1, 6, 4, 6, 5, 6, 4, 6, 5};
    logic [3:0] a[12]  = '{3, 2, 1, 9, 1, 0, 2, 0, 3, 0, 4, 0};
    logic [3:0] b[12]  = '{0, 0, 0, 0, 5, 10, 6, 10, 7, 10, 8, 10};
    logic [3:0] dd[12] = '{4, 3, 2, 1, 10, 0, 10, 0, 10, 0, 10, 0};
    for (int k = 0; k < stop_after; k++)
      v(0, 0, (k == 1), 2'd0, 0, o[k], a[k], b[k], dd[k], 1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; data_ready = 1'b0; load_coeff = 1'b0; coefficient_num = 2'd0; overflow = 1'b0;

    // reset state, then idle
    v(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    // coefficient loads 0..3
    v(0, 0, 1, 0, 0,  2, 0, 0, 5,  1, 0, 1, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 1, 1, 0,  2, 0, 0, 6,  1, 0, 0, 0);
    v(0, 0, 0, 1, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 1, 2, 0,  2, 0, 0, 7,  1, 0, 0, 0);
    v(0, 0, 0, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 1, 3, 0,  2, 0, 0, 8,  1, 0, 0, 0);
    v(0, 0, 0, 3, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    // full sample; load_coeff during SHIFT3 ignored
    v(0, 1, 0, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 1, 0, 0, 0,  5, 0, 0, 0,  1, 0, 0, 0);
    body_from_shift3(12);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    // short data_ready -> EIDLE, recovery with a clean sample
    v(0, 1, 0, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
    v(0, 1, 0, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 1, 0, 0, 0,  5, 0, 0, 0,  1, 0, 0, 0);
    body_from_shift3(6);                                 // SHIFT3..ADD0
    v(0, 0, 0, 0, 1,  6, 2, 6, 10, 1, 0, 0, 0);          // overflow in ADD0? no: ov applied in ADD0 below
    vecs.pop_back();
    v(0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 1);          // ADD0 + overflow -> EIDLE
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);
    v(0, 0, 1, 2, 0,  2, 0, 0, 7,  1, 0, 0, 0);          // EIDLE -> LOADC, err drops
    v(0, 0, 0, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    // overflow in MUL1 ignored, overflow in SUB3 -> EIDLE
    v(0, 1, 0, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 1, 0, 0, 0,  5, 0, 0, 0,  1, 0, 0, 0);
    body_from_shift3(7);                                 // SHIFT3..MUL1
    v(0, 0, 0, 0, 1,  5, 0, 10, 0, 1, 0, 0, 0);          // MUL1 + overflow -> SUB1
    v(0, 0, 0, 0, 0,  6, 3, 7, 10, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0,  4, 0, 10, 0, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0,  6, 4, 8, 10, 1, 0, 0, 0);
    v(0, 0, 0, 0, 0,  5, 0, 10, 0, 1, 0, 0, 0);
    v(0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 1);          // SUB3 + overflow -> EIDLE
    // both requests -> STORE; reset in MUL2
    v(0, 1, 1, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 1, 0, 0, 0,  5, 0, 0, 0,  1, 0, 0, 0);
    body_from_shift3(9);                                 // SHIFT3..MUL2
    v(1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    // reset held 2 cycles mid-run, data_ready held high through it
    v(0, 1, 0, 0, 0,  2, 0, 0, 9,  1, 1, 0, 0);
    v(0, 1, 0, 0, 0,  5, 0, 0, 0,  1, 0, 0, 0);
    v(1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(1, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; data_ready = vecs[i].dr; load_coeff = vecs[i].lc;
      coefficient_num = vecs[i].cn; overflow = vecs[i].ov;
      @(posedge clk); #1;
      applied++;
      if ({op, src1, src2, dest, modwait, cnt_up, clear, err} !==
          {vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].mw, vecs[i].cu, vecs[i].cl, vecs[i].er}) begin
        miscompares++;
        $display("FAIL vec%0d got op=%0d s1=%0d s2=%0d d=%0d mw=%b cu=%b cl=%b er=%b exp op=%0d s1=%0d s2=%0d d=%0d mw=%b cu=%b cl=%b er=%b",
                 i, op, src1, src2, dest, modwait, cnt_up, clear, err,
                 vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d,
                 vecs[i].mw, vecs[i].cu, vecs[i].cl, vecs[i].er);
      end
    end

    // Busy-length check: count modwait cycles for one sample, bounded.
    begin
      int n = 0;
      bit done = 0;
      reset = 1'b0; load_coeff = 1'b0; overflow = 1'b0; data_ready = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
        @(posedge clk); #1;
        if (c == 1) data_ready = 1'b0;
        if (modwait) n++;
        else done = 1;
      end
      applied++;
      if (!done || n != 14) begin
        miscompares++;
        $display("FAIL busy_len got %0d cycles (returned=%0d) exp 14", n, done);
      end
      applied++;
      if (op !== 3'd0 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL after_busy got op=%0d err=%b exp op=0 err=0", op, err);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
